fp_mac_sequencer: RTL

//  Nios II multi-cycle custom-instruction front end. Owns a 32-bit IEEE-754 single-precision accumulator.

---
 rtl/fp_mac_sequencer_pkg.sv | 37 +++
 rtl/fp_mac_sequencer_watchdog.sv | 37 +++
 rtl/fp_mac_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fp_mac_sequencer_pkg.sv
// fp_mac_sequencer_pkg: shared opcodes, core opcodes, FSM state encodings and
// small decode helpers for the fp32 MAC custom-instruction sequencer.
package fp_mac_sequencer_pkg;

  // CPU-side custom-instruction opcodes carried on n
  localparam logic [1:0] OP_CLR = 2'd0;
  localparam logic [1:0] OP_MAC = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_RD  = 2'd3;

  // Opcodes understood by the downstream FP add/sub/mul core
  localparam logic [1:0] CORE_ADD = 2'd0;
  localparam logic [1:0] CORE_MUL = 2'd2;

  // Width of the watchdog counter; TIMEOUT must fit in it
  localparam int WD_W = 5;

  // Sequencer states, kept as plain constants so older blocks can share them
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_MUL_ISS  = 3'd1;
  localparam state_t ST_MUL_WAIT = 3'd2;
  localparam state_t ST_ADD_ISS  = 3'd3;
  localparam state_t ST_ADD_WAIT = 3'd4;
  localparam state_t ST_FIN      = 3'd5;

  // True in the single-cycle states that strobe core_start
  function automatic logic is_issue_state(input state_t s);
    return (s == ST_MUL_ISS) || (s == ST_ADD_ISS);
  endfunction

  // True while waiting on the core, where core_done is honoured
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_MUL_WAIT) || (s == ST_ADD_WAIT);
  endfunction

endpackage

// File: rtl/fp_mac_sequencer_watchdog.sv
// fp_mac_sequencer_watchdog: small up-counter that measures how long the
// sequencer has been waiting on the FP core and flags when the limit is hit.
module fp_mac_sequencer_watchdog
  import fp_mac_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic            inc,
  output logic [WD_W-1:0] count,
  output logic            timeout
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] cnt;

  // Count waiting cycles; clear on issue, freeze whenever the CPU clock enable is low
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign count   = cnt;
  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/fp_mac_sequencer.sv
// fp_mac_sequencer: Nios II multi-cycle custom-instruction front end. Holds an
// fp32 accumulator and runs CLR / MAC / ADD / RD by issuing add and multiply
// commands to an external FP core over its start/done/n handshake. No FP math
// happens here; operands and results are moved bit-exact.
module fp_mac_sequencer
  import fp_mac_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7,
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        err,
  output logic        core_start,
  output logic [1:0]  core_n,
  output logic [31:0] core_dataa,
  output logic [31:0] core_datab,
  output logic        core_clk_en,
  input  logic [31:0] core_result,
  input  logic        core_done
);

  // Earliest watchdog count at which a well-behaved core may raise done
  localparam logic [WD_W-1:0] MUL_EARLY = WD_W'(MUL_LAT - 1);
  localparam logic [WD_W-1:0] ADD_EARLY = WD_W'(ADD_LAT - 1);

  state_t          state;
  logic [31:0]     acc;
  logic            err_q;
  logic [1:0]      core_n_q;
  logic [31:0]     core_dataa_q;
  logic [31:0]     core_datab_q;
  logic            in_iss;
  logic            in_wait;
  logic            wd_clr;
  logic            wd_inc;
  logic            wd_timeout;
  logic [WD_W-1:0] wd_cnt;

  assign in_iss  = is_issue_state(state);
  assign in_wait = is_wait_state(state);

  // The watchdog restarts on every issue and only runs while the core owes an answer
  assign wd_clr = in_iss;
  assign wd_inc = in_wait && !core_done && !wd_timeout;

  fp_mac_sequencer_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .en      (clk_en),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .count   (wd_cnt),
    .timeout (wd_timeout)
  );

  // Main sequencer: decodes the CPU opcode, walks the core through mul then add, and updates acc
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      acc          <= '0;
      err_q        <= 1'b0;
      core_n_q     <= CORE_ADD;
      core_dataa_q <= '0;
      core_datab_q <= '0;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (n)
              OP_CLR: begin
                acc   <= '0;
                err_q <= 1'b0;
                state <= ST_FIN;
              end
              OP_MAC: begin
                core_dataa_q <= dataa;
                core_datab_q <= datab;
                core_n_q     <= CORE_MUL;
                state        <= ST_MUL_ISS;
              end
              OP_ADD: begin
                core_dataa_q <= acc;
                core_datab_q <= dataa;
                core_n_q     <= CORE_ADD;
                state        <= ST_ADD_ISS;
              end
              default: begin
                state <= ST_FIN;
              end
            endcase
          end
        end
        ST_MUL_ISS: begin
          state <= ST_MUL_WAIT;
        end
        ST_MUL_WAIT: begin
          if (core_done) begin
            core_dataa_q <= acc;
            core_datab_q <= core_result;
            core_n_q     <= CORE_ADD;
            state        <= ST_ADD_ISS;
          end else if (wd_timeout) begin
            err_q <= 1'b1;
            state <= ST_FIN;
          end
        end
        ST_ADD_ISS: begin
          state <= ST_ADD_WAIT;
        end
        ST_ADD_WAIT: begin
          if (core_done) begin
            acc   <= core_result;
            state <= ST_FIN;
          end else if (wd_timeout) begin
            err_q <= 1'b1;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded from state and masked by reset so a reset cycle never issues or completes
  assign core_start  = in_iss && !reset;
  assign done        = (state == ST_FIN) && !reset;
  assign result      = acc;
  assign err         = err_q;
  assign core_n      = core_n_q;
  assign core_dataa  = core_dataa_q;
  assign core_datab  = core_datab_q;
  assign core_clk_en = clk_en;

  // Catch a core that answers earlier than its configured latency allows
  always_ff @(posedge clk) begin
    if (!reset && clk_en) begin
      if (state == ST_MUL_WAIT && wd_cnt < MUL_EARLY) begin
        assert (!core_done);
      end
      if (state == ST_ADD_WAIT && wd_cnt < ADD_EARLY) begin
        assert (!core_done);
      end
    end
  end

endmodule
